// File: rtl/instr_seq_if.sv
// instr_seq_if: sequencer control bus between the MCU datapath and instr_seq
interface instr_seq_if #(
    parameter int SIZE_CNT = 3,
    parameter int OPW = 4
);
    logic Run;
    logic Mem_Ready;
    logic [OPW-1:0] Instr_Op;
    logic Zero_Flag;
    logic [SIZE_CNT:0] Cnt;
    logic PC_Control;
    logic IR_Load;
    logic ALU_En;
    logic Reg_Write;
    logic Busy;
    logic Halted;
    modport master (
        output Run, Mem_Ready, Instr_Op, Zero_Flag,
        input Cnt, PC_Control, IR_Load, ALU_En, Reg_Write, Busy, Halted
    );
    modport slave (
        input Run, Mem_Ready, Instr_Op, Zero_Flag,
        output Cnt, PC_Control, IR_Load, ALU_En, Reg_Write, Busy, Halted
    );
endinterface

// File: rtl/instr_seq.sv
// instr_seq: instruction-cycle sequencer driving PC phase code and per-instruction strobes
module instr_seq #(
    parameter int SIZE_CNT = 3,
    parameter int OPW = 4
) (
    input logic clk,
    input logic rst,
    instr_seq_if.slave bus
);
    localparam logic [OPW-1:0] OP_HALT = '1;
    localparam logic [OPW-1:0] OP_JMP = OP_HALT - 1'b1;
    localparam logic [OPW-1:0] OP_JZ = OP_HALT - 2'd2;
    localparam logic [SIZE_CNT:0] C_FETCH = 0;
    localparam logic [SIZE_CNT:0] C_PCUPD = 1;
    localparam logic [SIZE_CNT:0] C_EXEC = 2;
    localparam logic [SIZE_CNT:0] C_WB = 3;

    typedef enum logic [2:0] {IDLE, FETCH, PCUPD, EXEC, WB, HALT} state_t;

    state_t st, nxt;
    logic [OPW-1:0] op;
    logic z;
    logic alu;

    assign alu = op != '0 && op < OP_JZ;

    always_comb begin
        nxt = st;
        case (st)
            IDLE: nxt = bus.Run ? FETCH : IDLE;
            FETCH: nxt = bus.Mem_Ready ? PCUPD : FETCH;
            PCUPD: nxt = op == OP_HALT ? HALT : EXEC;
            EXEC: nxt = WB;
            WB: nxt = bus.Run ? FETCH : IDLE;
            default: nxt = HALT;
        endcase
    end

    // IDLE and HALT share the all-ones code, so Cnt is a registered decode of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            bus.Cnt <= '1;
            bus.Busy <= 1'b0;
            bus.Halted <= 1'b0;
            op <= '0;
            z <= 1'b0;
        end else begin
            st <= nxt;
            bus.Cnt <= nxt == FETCH ? C_FETCH : nxt == PCUPD ? C_PCUPD :
                       nxt == EXEC ? C_EXEC : nxt == WB ? C_WB : '1;
            bus.Busy <= nxt inside {FETCH, PCUPD, EXEC, WB};
            bus.Halted <= nxt == HALT;
            if (st == FETCH && bus.Mem_Ready) op <= bus.Instr_Op;
            if (st == WB && alu) z <= bus.Zero_Flag;
        end
    end

    assign bus.IR_Load = st == FETCH && bus.Mem_Ready;
    assign bus.PC_Control = !(st == PCUPD && (op == OP_JMP || (op == OP_JZ && z)));
    assign bus.ALU_En = st == EXEC && alu;
    assign bus.Reg_Write = st == WB && alu;
endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: randomized instruction stream checked cycle by cycle against an instruction-level model
module tb_instr_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_seq_if #(.SIZE_CNT(3), .OPW(4)) bus ();
    instr_seq #(.SIZE_CNT(3), .OPW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    bit mz = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // checks one cycle's outputs at the falling edge, then advances to just past the next rising edge
    task automatic outs(input string tag, input int cnt, input bit ir, input bit pc,
                        input bit alu, input bit rw, input bit busy, input bit halted);
        @(negedge clk);
        check({tag, ".cnt"}, 32'(bus.Cnt), cnt);
        check({tag, ".ir"}, 32'(bus.IR_Load), 32'(ir));
        check({tag, ".pc"}, 32'(bus.PC_Control), 32'(pc));
        check({tag, ".alu"}, 32'(bus.ALU_En), 32'(alu));
        check({tag, ".rw"}, 32'(bus.Reg_Write), 32'(rw));
        check({tag, ".busy"}, 32'(bus.Busy), 32'(busy));
        check({tag, ".halted"}, 32'(bus.Halted), 32'(halted));
        @(posedge clk);
        #1;
    endtask

    // runs one instruction starting in FETCH; leaves the block in FETCH afterwards
    task automatic instr(input logic [3:0] op, input int waits, input bit zf,
                         input bit run_after, input bit rst_exec);
        bit alu;
        alu = op != 0 && op < 13;
        for (int i = 0; i < waits; i++) begin
            bus.Mem_Ready = 1'b0;
            bus.Instr_Op = 4'($urandom);
            bus.Run = 1'($urandom);
            outs("wait", 0, 0, 1, 0, 0, 1, 0);
        end
        bus.Mem_Ready = 1'b1;
        bus.Instr_Op = op;
        outs("fetch", 0, 1, 1, 0, 0, 1, 0);
        bus.Mem_Ready = 1'($urandom);
        bus.Instr_Op = 4'($urandom);
        bus.Run = 1'($urandom);
        outs("pcupd", 1, 0, !(op == 14 || (op == 13 && mz)), 0, 0, 1, 0);
        if (op == 15) begin
            bus.Run = 1'b1;
            repeat (3) outs("halt", 15, 0, 1, 0, 0, 0, 1);
            rst = 1'b1;
            outs("halt_rst", 15, 0, 1, 0, 0, 0, 1);
            rst = 1'b0;
            mz = 1'b0;
            outs("post_halt", 15, 0, 1, 0, 0, 0, 0);
            return;
        end
        bus.Zero_Flag = 1'($urandom);
        if (rst_exec) begin
            rst = 1'b1;
            outs("exec_rst", 2, 0, 1, alu, 0, 1, 0);
            rst = 1'b0;
            mz = 1'b0;
            bus.Run = 1'b1;
            outs("abort", 15, 0, 1, 0, 0, 0, 0);
            return;
        end
        outs("exec", 2, 0, 1, alu, 0, 1, 0);
        bus.Run = run_after;
        bus.Zero_Flag = zf;
        outs("wb", 3, 0, 1, 0, alu, 1, 0);
        if (alu) mz = zf;
        if (!run_after) begin
            bus.Run = 1'b1;
            outs("idle", 15, 0, 1, 0, 0, 0, 0);
        end
    endtask

    initial begin
        logic [3:0] op;
        bus.Run = 1'b1;
        bus.Mem_Ready = 1'b0;
        bus.Instr_Op = '0;
        bus.Zero_Flag = 1'b0;
        @(posedge clk);
        #1;
        outs("rst_run", 15, 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        outs("start", 15, 0, 1, 0, 0, 0, 0);
        instr(4'd3, 0, 1'b1, 1'b1, 1'b0);
        instr(4'd13, 0, 1'b0, 1'b1, 1'b0);
        instr(4'd5, 3, 1'b0, 1'b1, 1'b0);
        instr(4'd13, 0, 1'b0, 1'b1, 1'b0);
        instr(4'd14, 1, 1'b0, 1'b1, 1'b0);
        instr(4'd0, 0, 1'b1, 1'b0, 1'b0);
        instr(4'd7, 0, 1'b1, 1'b1, 1'b1);
        instr(4'd14, 0, 1'b0, 1'b1, 1'b0);
        instr(4'd15, 2, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 15 && $urandom_range(0, 3) != 0) op = 4'd13;
            instr(op, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                  1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_seq.md
# instr_seq

Instruction-cycle sequencer for the 8-bit MCU core. It generates the phase count `Cnt` and the branch select `PC_Control` that drive the program counter. It also produces the instruction-register load, ALU enable and register-write strobes for each instruction. It handles memory wait-states, the conditional branch on a latched zero flag, and halt.

## Interface
Parameters:
- `SIZE_CNT`, default 3. `Cnt` is `SIZE_CNT+1` bits wide. It must be ≥1.
- `OPW`, default 4. Opcode width.

Ports:
- `clk`  in  1. Single clock; all state changes on its rising edge.
- `rst`  in  1. Synchronous, active-high reset.
- `Run`  in  1. Start/continue request.
- `Mem_Ready`  in  1. Instruction memory data valid.
- `Instr_Op`  in  OPW. Opcode from instruction memory. Valid when `Mem_Ready`=1.
- `Zero_Flag`  in  1. ALU zero result.
- `Cnt`  out  SIZE_CNT+1. Phase code to the PC. The PC advances on every edge where `Cnt`==1.
- `PC_Control`  out  1. 1 = PC increments; 0 = PC loads the ALU/jump target.
- `IR_Load`  out  1. Instruction register load strobe.
- `ALU_En`  out  1. ALU operation enable.
- `Reg_Write`  out  1. Register-file write strobe.
- `Busy`  out  1. An instruction is in progress.
- `Halted`  out  1. A HALT opcode was executed.

## Operation
- Internal registers: state, `op` (OPW bits), `z` (1 bit).
- States and their `Cnt` codes:
  - IDLE: all-ones (15 at default)
  - FETCH: 0
  - PCUPD: 1
  - EXEC: 2
  - WB: 3
  - HALT: all-ones
- `Cnt` is driven directly from the state register. Other outputs are decoded from state, `op` and `z`.
- Opcode classes:
  - `0`: NOP
  - all-ones: HALT
  - all-ones−1: JMP
  - all-ones−2: JZ
  - all others: ALU op
- Transitions:
  - IDLE→FETCH when `Run`=1.
  - FETCH stays in FETCH while `Mem_Ready`=0. FETCH→PCUPD when `Mem_Ready`=1; on that edge, `op` latches `Instr_Op`.
  - PCUPD→HALT if `op`=HALT; otherwise PCUPD→EXEC. PCUPD always lasts exactly one cycle.
  - EXEC→WB.
  - WB→FETCH if `Run`=1; WB→IDLE if `Run`=0.
  - HALT is left only by `rst`.
- Strobes:
  - `IR_Load` = (state==FETCH && `Mem_Ready`).
  - `PC_Control` = 0 only in PCUPD when `op`=JMP, or when `op`=JZ and `z`=1. It is 1 in all other cycles.
  - `ALU_En` = 1 in EXEC for ALU ops only.
  - `Reg_Write` = 1 in WB for ALU ops only. NOP, JMP and JZ produce no `ALU_En` or `Reg_Write`.
- Zero flag: `z` loads `Zero_Flag` on the WB edge of ALU ops only. JZ tests the flag from the most recent ALU op.
- `Busy` = 1 in FETCH, PCUPD, EXEC and WB.
- `Halted` = 1 in HALT.
- HALT still increments the PC in its PCUPD cycle.
- `Cnt` never equals 1 outside PCUPD. The PC therefore stays frozen in IDLE, HALT and FETCH wait-states, and after reset.

## Timing
- Reset values, visible in the first cycle after `rst` is sampled high:
  - state = IDLE, `Cnt` = all-ones.
  - `PC_Control`=1; `IR_Load`, `ALU_En`, `Reg_Write`, `Busy`, `Halted` = 0.
  - `op`=0, `z`=0.
- Reset mid-instruction aborts it immediately:
  - No further PC advance.
  - No `Reg_Write` for the aborted instruction.
  - `rst` has priority over every transition.
- Instruction latency:
  - 4 cycles with no wait-states (FETCH, PCUPD, EXEC, WB).
  - Each cycle of `Mem_Ready`=0 in FETCH adds 1 cycle.
  - Back-to-back instructions: WB is followed directly by FETCH, with no bubble.
- `Run` is sampled only in IDLE and WB. Dropping it mid-instruction completes the current instruction, then enters IDLE.
- `Mem_Ready` already high on FETCH entry: `IR_Load` pulses in that same cycle, for exactly one cycle.
- `Run` and HALT together: HALT wins, and the block enters HALT regardless of `Run`.
- `Run` with `rst` asserted in the same cycle: the block stays in IDLE.

## Test plan
- Reset, then `Run`=1 with `Mem_Ready`=1 and op=3. Required:
  - `Cnt` sequence 15,0,1,2,3,0…
  - `IR_Load` high at `Cnt`=0.
  - `PC_Control`=1 at `Cnt`=1.
  - `ALU_En` high at `Cnt`=2; `Reg_Write` high at `Cnt`=3.
  - Exactly one `Cnt`=1 cycle per instruction.
- `Mem_Ready` held 0 for 3 cycles in FETCH. Required: `Cnt`=0 for 4 cycles, `IR_Load` only in the 4th, instruction takes 7 cycles total.
- ALU op with `Zero_Flag`=1 at WB, then JZ (op=13). Required: `PC_Control`=0 at `Cnt`=1 and no `ALU_En`/`Reg_Write`. Repeat with `Zero_Flag`=0: `PC_Control`=1.
- JMP (op=14) after reset with `z`=0. Required: `PC_Control`=0 at PCUPD. NOP (op=0): `Cnt` 0–3 with no strobes.
- HALT (op=15). Required:
  - `Cnt`=1 once, then 15 thereafter.
  - `Halted`=1, `Busy`=0.
  - Stays halted with `Run`=1; only `rst` returns the block to IDLE with `Halted`=0.
- `rst` asserted during EXEC. Required: next cycle `Cnt`=15, all strobes 0, no `Reg_Write` pulse. `Run`=0 sampled at WB: the block goes to IDLE with `Cnt`=15.
